// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC rotator.
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ROTATE  = 2'd1,
    ST_CORRECT = 2'd2
  } state_t;

  localparam logic [1:0] Q1 = 2'b00;
  localparam logic [1:0] Q2 = 2'b01;
  localparam logic [1:0] Q3 = 2'b10;
  localparam logic [1:0] Q4 = 2'b11;

  // Angles carry 12 fractional degree bits
  localparam int unsigned PHI_FRAC_W = 12;
  localparam int unsigned ATAN_IDX_W = 5;
  // 90.0 degrees in angle units (368640)
  localparam int unsigned PHI_90     = 90 << PHI_FRAC_W;

  // CORDIC gain 0.6072529350 scaled by 2^30
  localparam longint unsigned CORDIC_K_Q30 = 64'd652032874;

  // Gain rounded to frac_w fractional bits (159188 for 18 bits)
  function automatic int unsigned cordic_k(input int unsigned frac_w);
    longint unsigned r;
    if (frac_w >= 30) begin
      r = CORDIC_K_Q30;
    end else begin
      r = (CORDIC_K_Q30 + (64'd1 << (29 - frac_w))) >> (30 - frac_w);
    end
    return 32'(r);
  endfunction

  // round(atan(2^-idx) in degrees * 2^frac_w), tabulated at 12 fractional bits
  function automatic int unsigned cordic_atan(input int unsigned idx,
                                              input int unsigned frac_w);
    int unsigned base;
    case (idx)
      32'd0:   base = 32'd184320;
      32'd1:   base = 32'd108810;
      32'd2:   base = 32'd57492;
      32'd3:   base = 32'd29184;
      32'd4:   base = 32'd14649;
      32'd5:   base = 32'd7331;
      32'd6:   base = 32'd3667;
      32'd7:   base = 32'd1833;
      32'd8:   base = 32'd917;
      32'd9:   base = 32'd458;
      32'd10:  base = 32'd229;
      32'd11:  base = 32'd115;
      32'd12:  base = 32'd57;
      32'd13:  base = 32'd29;
      32'd14:  base = 32'd14;
      32'd15:  base = 32'd7;
      32'd16:  base = 32'd4;
      32'd17:  base = 32'd2;
      32'd18:  base = 32'd1;
      default: base = 32'd0;
    endcase
    if (frac_w >= PHI_FRAC_W) begin
      return base << (frac_w - PHI_FRAC_W);
    end
    return (base + (32'd1 << (PHI_FRAC_W - 1 - frac_w))) >> (PHI_FRAC_W - frac_w);
  endfunction

endpackage

// File: rtl/cordic_atan_lut.sv
// Arctangent table: micro-rotation index -> atan(2^-i) in angle units.
module cordic_atan_lut
  import cordic_pkg::*;
#(
  parameter int unsigned PHI_WIDTH = 22
) (
  input  logic [ATAN_IDX_W-1:0] idx,
  output logic [PHI_WIDTH-1:0]  atan_val
);

  // Pure table lookup
  always_comb begin
    atan_val = PHI_WIDTH'(cordic_atan(32'(idx), PHI_FRAC_W));
  end

endmodule

// File: rtl/cordic_rotator.sv
// Iterative CORDIC rotation engine: sin/cos of quarter*90 + residual angle.
// One micro-rotation per clock, then a quarter-correction/saturation step.
// Optional build macro CORDIC_RANGE_CHECK_EN: residual above 90.0 deg skips
// rotation and returns zero results with err set.
module cordic_rotator
  import cordic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 20,
  parameter int unsigned PHI_WIDTH     = 22,
  parameter int unsigned PHI_WIDTH_INT = 9,
  parameter int unsigned ITERATIONS    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [PHI_WIDTH-1:0]         phi_in,
  input  logic [1:0]                   quarter,
  output logic                         busy,
  output logic                         done,
  output logic signed [DATA_WIDTH-1:0] sin_out,
  output logic signed [DATA_WIDTH-1:0] cos_out,
  output logic                         err
);

  localparam int unsigned XW    = DATA_WIDTH + 2;
  localparam int unsigned MAG_W = PHI_WIDTH - 1;

  localparam logic signed [XW-1:0] K_INIT  = XW'(cordic_k(DATA_WIDTH - 2));
  localparam logic signed [XW:0]   SAT_MAX = (XW+1)'((64'd1 << (DATA_WIDTH - 1)) - 64'd1);
  localparam logic signed [XW:0]   SAT_MIN = -SAT_MAX - (XW+1)'(1);
  localparam logic [ATAN_IDX_W-1:0] LAST_ITER = ATAN_IDX_W'(ITERATIONS - 1);

  state_t                  state;
  logic [ATAN_IDX_W-1:0]   iter;
  logic [1:0]              quarter_q;
  logic signed [XW-1:0]    x;
  logic signed [XW-1:0]    y;
  logic signed [PHI_WIDTH-1:0] z;

  logic [MAG_W-1:0]        phi_mag;
  logic                    phi_sign_unused;
  logic [PHI_WIDTH-1:0]    atan_val;
  logic signed [PHI_WIDTH-1:0] atan_s;
  logic signed [XW-1:0]    x_sh;
  logic signed [XW-1:0]    y_sh;
  logic signed [XW-1:0]    x_nxt;
  logic signed [XW-1:0]    y_nxt;
  logic signed [PHI_WIDTH-1:0] z_nxt;
  logic signed [XW:0]      xe;
  logic signed [XW:0]      ye;
  logic signed [XW:0]      sin_raw;
  logic signed [XW:0]      cos_raw;
  logic signed [DATA_WIDTH-1:0] sin_sat;
  logic signed [DATA_WIDTH-1:0] cos_sat;

`ifdef CORDIC_RANGE_CHECK_EN
  logic range_flag;
`endif

  // Angle magnitude only; the sign bit is carried by the quarter
  assign phi_mag         = phi_in[PHI_WIDTH-2:0];
  assign phi_sign_unused = phi_in[PHI_WIDTH-1];

  cordic_atan_lut #(
    .PHI_WIDTH (PHI_WIDTH)
  ) u_atan_lut (
    .idx      (iter),
    .atan_val (atan_val)
  );

  assign atan_s = signed'(atan_val);
  assign x_sh   = x >>> iter;
  assign y_sh   = y >>> iter;

  // One micro-rotation towards z = 0
  always_comb begin
    x_nxt = x;
    y_nxt = y;
    z_nxt = z;
    if (!z[PHI_WIDTH-1]) begin
      x_nxt = x - y_sh;
      y_nxt = y + x_sh;
      z_nxt = z - atan_s;
    end else begin
      x_nxt = x + y_sh;
      y_nxt = y - x_sh;
      z_nxt = z + atan_s;
    end
  end

  // Clamp a widened result into the output format
  function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [XW:0] v);
    if (v > SAT_MAX) begin
      return DATA_WIDTH'(SAT_MAX);
    end
    if (v < SAT_MIN) begin
      return DATA_WIDTH'(SAT_MIN);
    end
    return DATA_WIDTH'(v);
  endfunction

  // Map first-quarter (cos, sin) onto the requested quarter
  always_comb begin
    xe      = {x[XW-1], x};
    ye      = {y[XW-1], y};
    sin_raw = ye;
    cos_raw = xe;
    case (quarter_q)
      Q1: begin sin_raw = ye;  cos_raw = xe;  end
      Q2: begin sin_raw = xe;  cos_raw = -ye; end
      Q3: begin sin_raw = -ye; cos_raw = -xe; end
      Q4: begin sin_raw = -xe; cos_raw = ye;  end
      default: begin sin_raw = ye; cos_raw = xe; end
    endcase
    sin_sat = sat(sin_raw);
    cos_sat = sat(cos_raw);
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      iter      <= '0;
      quarter_q <= Q1;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      sin_out   <= '0;
      cos_out   <= '0;
`ifdef CORDIC_RANGE_CHECK_EN
      range_flag <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            quarter_q <= quarter;
            z         <= {1'b0, phi_mag};
            x         <= K_INIT;
            y         <= '0;
            iter      <= '0;
            busy      <= 1'b1;
`ifdef CORDIC_RANGE_CHECK_EN
            range_flag <= (phi_mag > MAG_W'(PHI_90));
            state      <= (phi_mag > MAG_W'(PHI_90)) ? ST_CORRECT : ST_ROTATE;
`else
            state     <= ST_ROTATE;
`endif
          end
        end
        ST_ROTATE: begin
          x <= x_nxt;
          y <= y_nxt;
          z <= z_nxt;
          if (iter == LAST_ITER) begin
            iter  <= '0;
            state <= ST_CORRECT;
          end else begin
            iter <= iter + ATAN_IDX_W'(1);
          end
        end
        ST_CORRECT: begin
`ifdef CORDIC_RANGE_CHECK_EN
          sin_out <= range_flag ? '0 : sin_sat;
          cos_out <= range_flag ? '0 : cos_sat;
          err     <= range_flag;
`else
          sin_out <= sin_sat;
          cos_out <= cos_sat;
          err     <= 1'b0;
`endif
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
